// File: rtl/ahb_lite_pkg.sv
// Shared types for the AHB-Lite memory slave.
//   htrans_e      : AHB transfer type encoding
//   hsize_e       : AHB transfer size encoding
//   hresp_e       : AHB response encoding
//   slave_state_e : data-phase state of the slave
//   clamp_size()  : limits a transfer size to the widest size the bus carries
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  localparam int MAX_WAIT = 15;

  function automatic logic [1:0] clamp_size(input logic [2:0] size,
                                            input logic [1:0] max_size);
    return (size > {1'b0, max_size}) ? max_size : size[1:0];
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-lane RAM behind the AHB-Lite slave.
//   clk   : write clock
//   we    : per-lane write enable
//   waddr : word index for writes
//   wdata : write data, one byte per lane (lane 0 = lowest address)
//   raddr : word index for reads
//   rdata : asynchronous read data
// Each lane is its own byte-wide array so sub-word writes need no read-modify-write.
module ahb_mem_array #(
  parameter int WIDX_W    = 6,
  parameter int NUM_LANES = 4
) (
  input  logic                       clk,
  input  logic [NUM_LANES-1:0]       we,
  input  logic [WIDX_W-1:0]          waddr,
  input  logic [NUM_LANES-1:0][7:0]  wdata,
  input  logic [WIDX_W-1:0]          raddr,
  output logic [NUM_LANES-1:0][7:0]  rdata
);

  localparam int DEPTH = 1 << WIDX_W;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
      if (we[i]) mem[waddr] <= wdata[i];

    assign rdata[i] = mem[raddr];
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: byte-addressable RAM with programmable wait states,
// sub-word writes and optional error responses.
//   HCLK, HRESET           : clock, asynchronous active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS : address phase
//   HBURST/HPROT/HMASTLOCK : accepted, not used
//   HREADY                 : bus ready (HREADYOUT looped back at top level)
//   HWDATA                 : write data (data phase)
//   HRDATA/HREADYOUT/HRESP : data-phase response
// Build option: define AHB_LITE_MEM_ERR_RESP_EN to answer oversize or misaligned
// transfers with a two-cycle ERROR; otherwise such transfers are clamped to the
// bus width, aligned down and performed with OKAY.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [1:0]        HTRANS,
  input  logic [3:0]        HPROT,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB     = DATA_W / 8;
  localparam int OFFW   = $clog2(NB);
  localparam int WIDX_W = ADDR_W - OFFW;

  slave_state_e      state;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              hready_q;
  hresp_e            hresp_q;

  htrans_e           trans;
  logic              accept;
  logic              illegal;
  logic [NB-1:0]     be;
  logic [1:0]        eff_size;
  logic [OFFW-1:0]   off_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign trans  = htrans_e'(HTRANS);
  assign accept = HSEL && HREADY && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);

`ifdef AHB_LITE_MEM_ERR_RESP_EN
  logic [OFFW-1:0] amask;
  assign amask   = OFFW'((8'd1 << HSIZE) - 8'd1);
  assign illegal = (HSIZE > 3'(OFFW)) || ((HADDR[OFFW-1:0] & amask) != '0);
`else
  assign illegal = 1'b0;
`endif

  // Data-phase FSM. HREADYOUT/HRESP are registered alongside the state so they
  // come straight off flops.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= RESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wcnt == 4'd0) begin
            state    <= ST_DATA;
            hready_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= RESP_ERROR;
        end
        ST_IDLE, ST_DATA, ST_ERR2: begin
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
          if (accept) begin
            addr_q  <= HADDR;
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (illegal) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= RESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              // counter runs WAIT_STATES-1 .. 0, one HREADYOUT-low cycle each
              state    <= ST_WAIT;
              hready_q <= 1'b0;
              wcnt     <= 4'(WAIT_STATES - 1);
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte lanes: a lane is written when it falls in the same size-aligned block
  // as the transfer address; this also performs the alignment of stray low bits.
  assign off_q    = addr_q[OFFW-1:0];
  assign eff_size = clamp_size(size_q, 2'(OFFW));

  for (genvar i = 0; i < NB; i++) begin : g_be
    localparam logic [OFFW-1:0] LANE = OFFW'(i);
    assign be[i] = (state == ST_DATA) && write_q &&
                   ((LANE >> eff_size) == (off_q >> eff_size));
  end

  ahb_mem_array #(
    .WIDX_W    (WIDX_W),
    .NUM_LANES (NB)
  ) u_mem (
    .clk   (HCLK),
    .we    (be),
    .waddr (addr_q[ADDR_W-1:OFFW]),
    .wdata (HWDATA),
    .raddr (addr_q[ADDR_W-1:OFFW]),
    .rdata (mem_rdata)
  );

  // Async read: a write committed at the previous edge is already visible.
  assign HRDATA    = (state == ST_DATA && !write_q) ? mem_rdata : '0;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: two instances (0 and 3 wait states), a
// pipelined bus driver, a byte-array reference model checked every cycle, and
// directed transfers with literal expectations.
module tb_ahb_lite_mem_slave;

`ifdef AHB_LITE_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    logic        resp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel    [2];
  logic [7:0]  addr   [2];
  logic        write  [2];
  logic [2:0]  size   [2];
  logic [1:0]  trans  [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        rdy_o  [2];
  logic        resp_o [2];
  logic        hready [2];
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hlock;

  int checks = 0;
  int fails  = 0;

  tx_t  txq [$];
  res_t res [$];
  logic [7:0] mm [2][256];

  always #5 clk = ~clk;

  assign hready[0] = rdy_o[0];
  assign hready[1] = rdy_o[1];

  ahb_lite_mem_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(addr[0]), .HWRITE(write[0]),
    .HSIZE(size[0]), .HBURST(hburst), .HTRANS(trans[0]), .HPROT(hprot),
    .HMASTLOCK(hlock), .HREADY(hready[0]), .HWDATA(wdata[0]), .HRDATA(rdata[0]),
    .HREADYOUT(rdy_o[0]), .HRESP(resp_o[0]));

  ahb_lite_mem_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS1)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(addr[1]), .HWRITE(write[1]),
    .HSIZE(size[1]), .HBURST(hburst), .HTRANS(trans[1]), .HPROT(hprot),
    .HMASTLOCK(hlock), .HREADY(hready[1]), .HWDATA(wdata[1]), .HRDATA(rdata[1]),
    .HREADYOUT(rdy_o[1]), .HRESP(resp_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_illegal(input logic [7:0] a, input logic [2:0] s);
    if (!ERR_EN) return 1'b0;
    if (s > 3'd2) return 1'b1;
    return (int'(a) % (1 << s)) != 0;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [7:0] a);
    int b = int'(a) & 8'hFC;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  task automatic model_write(input int d, input logic [7:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    int es   = (s > 3'd2) ? 2 : int'(s);
    int n    = 1 << es;
    int base = int'(a) - (int'(a) % n);
    for (int k = 0; k < n; k++)
      mm[d][base+k] = 8'(wd >> (8 * ((base + k) % 4)));
  endtask

  // Per-cycle checker: follows the transfer in its data phase and predicts
  // HREADYOUT/HRESP/HRDATA from the bus rules alone.
  task automatic mon(input int d);
    bit          pend = 1'b0;
    bit          pill = 1'b0;
    bit          pw   = 1'b0;
    logic [7:0]  pa   = '0;
    logic [2:0]  ps   = '0;
    int          age  = 0;
    int          ws   = (d == 0) ? WS0 : WS1;
    bit          erdy;
    logic        eresp;
    logic [31:0] edata;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        chk($sformatf("d%0d_rst_ready", d), 32'(rdy_o[d]), 32'd1);
        chk($sformatf("d%0d_rst_resp", d), 32'(resp_o[d]), 32'd0);
        chk($sformatf("d%0d_rst_rdata", d), rdata[d], 32'd0);
        continue;
      end
      erdy  = 1'b1;
      eresp = 1'b0;
      edata = '0;
      if (pend) begin
        if (pill) begin
          eresp = 1'b1;
          erdy  = (age >= 1);
        end else begin
          erdy = (age >= ws);
          if (erdy && !pw) edata = model_word(d, pa);
        end
      end
      chk($sformatf("d%0d_ready", d), 32'(rdy_o[d]), 32'(erdy));
      chk($sformatf("d%0d_resp", d), 32'(resp_o[d]), 32'(eresp));
      chk($sformatf("d%0d_rdata", d), rdata[d], edata);
      if (erdy) begin
        if (pend && !pill && pw) model_write(d, pa, ps, wdata[d]);
        pend = sel[d] && trans[d][1];
        if (pend) begin
          pa   = addr[d];
          ps   = size[d];
          pw   = write[d];
          pill = is_illegal(addr[d], size[d]);
          age  = 0;
        end
      end else begin
        age++;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle(input int d);
    sel[d] = 1'b0; trans[d] = 2'b00; write[d] = 1'b0;
    addr[d] = '0; size[d] = '0; wdata[d] = '0;
  endtask

  task automatic push(input bit w, input logic [7:0] a, input logic [2:0] s,
                      input logic [31:0] wd);
    tx_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.write = w; t.addr = a; t.size = s; t.wdata = wd;
    txq.push_back(t);
  endtask

  // Issues txq as a pipelined sequence on instance d; records one res entry per
  // completed data phase.
  task automatic run(input int d);
    tx_t  t;
    tx_t  dp;
    bit   dpv = 1'b0;
    int   w;
    res_t r;
    while (txq.size() > 0 || dpv) begin
      if (txq.size() > 0) t = txq.pop_front();
      else begin
        t.sel = 1'b0; t.trans = 2'b00; t.write = 1'b0; t.addr = '0; t.size = '0; t.wdata = '0;
      end
      sel[d] = t.sel; trans[d] = t.trans; addr[d] = t.addr;
      write[d] = t.write; size[d] = t.size;
      wdata[d] = dpv ? dp.wdata : $urandom;
      hburst = 3'($urandom); hprot = 4'($urandom); hlock = 1'($urandom);
      w = 0;
      forever begin
        @(negedge clk);
        if (rdy_o[d]) break;
        w++;
        if (w > 20) begin
          checks++; fails++;
          $display("FAIL d%0d_ready_timeout actual=low required=high within 20 cycles", d);
          idle(d);
          txq.delete();
          return;
        end
        @(posedge clk); #1;
      end
      if (dpv) begin
        r.rdata = rdata[d]; r.waits = w; r.resp = resp_o[d];
        res.push_back(r);
      end
      @(posedge clk); #1;
      dp  = t;
      dpv = t.sel && t.trans[1];
    end
    idle(d);
  endtask

  task automatic rand_seq(input int n);
    tx_t t;
    for (int i = 0; i < n; i++) begin
      t.sel   = ($urandom_range(0, 9) != 0);
      t.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1))
                                            : 2'($urandom_range(2, 3));
      t.write = 1'($urandom_range(0, 1));
      t.addr  = 8'($urandom);
      t.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                            : 3'($urandom_range(0, 2));
      t.wdata = $urandom;
      txq.push_back(t);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1;
    idle(0); idle(1);
    hburst = '0; hprot = '0; hlock = 1'b0;
    fork
      mon(0);
      mon(1);
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fill both memories so the model starts fully known
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a += 4) push(1'b1, 8'(a), 3'd2, $urandom);
      run(d);
    end

    // 1: write/read word, zero wait
    res.delete();
    push(1'b1, 8'h10, 3'd2, 32'hDEADBEEF);
    push(1'b0, 8'h10, 3'd2, 32'h0);
    run(0);
    if (res.size() == 2) begin
      chk("t1_wr_waits", 32'(res[0].waits), 32'd0);
      chk("t1_rd_data", res[1].rdata, 32'hDEADBEEF);
      chk("t1_rd_waits", 32'(res[1].waits), 32'd0);
      chk("t1_rd_resp", 32'(res[1].resp), 32'd0);
    end else chk("t1_count", 32'(res.size()), 32'd2);

    // 2: byte write into a cleared word
    res.delete();
    push(1'b1, 8'h10, 3'd2, 32'h0000_0000);
    push(1'b1, 8'h11, 3'd0, 32'h5555_AA55);
    push(1'b0, 8'h10, 3'd2, 32'h0);
    run(0);
    if (res.size() == 3) chk("t2_byte_merge", res[2].rdata, 32'h0000AA00);
    else chk("t2_count", 32'(res.size()), 32'd3);

    // 4: back-to-back write then read of the same word
    res.delete();
    push(1'b1, 8'h04, 3'd2, 32'h12345678);
    push(1'b0, 8'h04, 3'd2, 32'h0);
    run(0);
    if (res.size() == 2) chk("t4_raw", res[1].rdata, 32'h12345678);
    else chk("t4_count", 32'(res.size()), 32'd2);

    // 3: three wait states on a read
    res.delete();
    push(1'b1, 8'h20, 3'd2, 32'h01020304);
    push(1'b0, 8'h20, 3'd2, 32'h0);
    run(1);
    if (res.size() == 2) begin
      chk("t3_rd_waits", 32'(res[1].waits), 32'd3);
      chk("t3_rd_data", res[1].rdata, 32'h01020304);
    end else chk("t3_count", 32'(res.size()), 32'd2);

    // 5: misaligned word write (ERROR, or aligned down when errors are off)
    res.delete();
    push(1'b1, 8'h00, 3'd2, 32'h0BADF00D);
    push(1'b1, 8'h02, 3'd2, 32'hCAFEF00D);
    push(1'b0, 8'h00, 3'd2, 32'h0);
    run(1);
    if (res.size() == 3) begin
      chk("t5_mis_resp", 32'(res[1].resp), 32'(ERR_EN));
      chk("t5_mis_waits", 32'(res[1].waits), ERR_EN ? 32'd1 : 32'd3);
      chk("t5_readback", res[2].rdata, ERR_EN ? 32'h0BADF00D : 32'hCAFEF00D);
    end else chk("t5_count", 32'(res.size()), 32'd3);

    // random traffic on both instances
    rand_seq(200); run(0);
    rand_seq(200); run(1);

    // 6: reset in the middle of a waited write
    res.delete();
    push(1'b1, 8'h30, 3'd2, 32'h77665544);
    run(1);
    sel[1] = 1'b1; trans[1] = 2'b10; write[1] = 1'b1; addr[1] = 8'h30; size[1] = 3'd2;
    @(posedge clk); #1;
    idle(1);
    wdata[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("t6_in_wait", 32'(rdy_o[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(rdy_o[1]), 32'd1);
    chk("t6_rst_resp", 32'(resp_o[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    res.delete();
    push(1'b0, 8'h30, 3'd2, 32'h0);
    run(1);
    if (res.size() == 1) chk("t6_unchanged", res[0].rdata, 32'h77665544);
    else chk("t6_count", 32'(res.size()), 32'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog actual=running required=finished by 300000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
